// File: rtl/ex_hazard_ctrl.sv
// Execute-stage sequencing: redirect flushes, load-use bubbles and
// the multicycle start/done handshake, plus stall statistics.
module ex_hazard_ctrl #(
  parameter int LD_STALL_CYC = 1,
  parameter int MC_TIMEOUT   = 64,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             branch_taken_ex,
  input  logic             pc_src_ex,
  input  logic             ex_is_load,
  input  logic             ex_rf_wb,
  input  logic [4:0]       rd_ex,
  input  logic [4:0]       rs1_dec,
  input  logic [4:0]       rs2_dec,
  input  logic             rs1_used,
  input  logic             rs2_used,
  input  logic             ex_mc_op,
  input  logic             mc_done,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             mc_start,
  output logic             mc_timeout,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int WW = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;

  localparam logic [1:0] S_RUN = 2'd0;
  localparam logic [1:0] S_LD  = 2'd1;
  localparam logic [1:0] S_MC  = 2'd2;

  localparam logic [2:0]    LD_LAST = 3'(LD_STALL_CYC - 1);
  localparam logic [WW-1:0] TO_LAST = WW'(MC_TIMEOUT - 1);

  logic [1:0]       state_q, state_d;
  logic [2:0]       ld_cnt_q, ld_cnt_d;
  logic [WW-1:0]    wait_cnt_q, wait_cnt_d;
  logic             mc_timeout_q, mc_timeout_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic redirect;
  logic rs1_hit;
  logic rs2_hit;
  logic load_use;

  assign redirect = branch_taken_ex | pc_src_ex;
  assign rs1_hit  = rs1_used & (rs1_dec == rd_ex);
  assign rs2_hit  = rs2_used & (rs2_dec == rd_ex);
  assign load_use = ex_is_load & ex_rf_wb & (rd_ex != 5'd0)
                  & (rs1_hit | rs2_hit);

  always_comb begin
    state_d      = state_q;
    ld_cnt_d     = ld_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    mc_timeout_d = mc_timeout_q;
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    mc_start     = 1'b0;

    unique case (state_q)
      S_RUN: begin
        if (redirect) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (ex_mc_op) begin
          mc_start     = 1'b1;
          pc_en        = 1'b0;
          if_id_en     = 1'b0;
          id_ex_en     = 1'b0;
          ex_mem_flush = 1'b1;
          state_d      = S_MC;
          wait_cnt_d   = '0;
        end else if (load_use) begin
          pc_en       = 1'b0;
          if_id_en    = 1'b0;
          id_ex_flush = 1'b1;
          if (LD_STALL_CYC > 1) begin
            state_d  = S_LD;
            ld_cnt_d = 3'd1;
          end
        end
      end
      S_LD: begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_flush = 1'b1;
        ld_cnt_d    = ld_cnt_q + 3'd1;
        if (ld_cnt_q == LD_LAST) state_d = S_RUN;
      end
      S_MC: begin
        if (mc_done) begin
          state_d = S_RUN;
        end else begin
          pc_en        = 1'b0;
          if_id_en     = 1'b0;
          id_ex_en     = 1'b0;
          ex_mem_flush = 1'b1;
          wait_cnt_d   = wait_cnt_q + WW'(1);
          // give up on the unit; EX is released next cycle
          if (wait_cnt_q == TO_LAST) begin
            mc_timeout_d = 1'b1;
            state_d      = S_RUN;
          end
        end
      end
      default: state_d = S_RUN;
    endcase

    if (rst) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
      mc_start     = 1'b0;
    end

    stall_cnt_d = stall_cnt_q;
    if (!pc_en && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_RUN;
      ld_cnt_q     <= '0;
      wait_cnt_q   <= '0;
      mc_timeout_q <= 1'b0;
      stall_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      ld_cnt_q     <= ld_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      mc_timeout_q <= mc_timeout_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign mc_timeout = mc_timeout_q;
  assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Bench for ex_hazard_ctrl: two configurations driven in lockstep
// against a cycle model, with table rows and corner sequences.
module tb_ex_hazard_ctrl;

  typedef struct packed {
    logic       rst, br, jp, ld, wb;
    logic [4:0] rd, rs1, rs2;
    logic       u1, u2, mc, done;
  } in_t;

  typedef struct {
    in_t        i;
    logic [6:0] o;
    int         cnt;
  } row_t;

  typedef struct {
    logic [6:0]  oa, ob;
    logic        ta, tb;
    logic [63:0] ca, cb;
  } smp_t;

  localparam int TO = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, br, jp, ld, wb, u1, u2, mc, done;
  logic [4:0] rd, rs1, rs2;

  logic        pa, fa_en, ia, ffa, fia, fea, sa, ta;
  logic        pb, fb_en, ib, ffb, fib, feb, sb, tb;
  logic [31:0] cnt_a;
  logic [3:0]  cnt_b;

  ex_hazard_ctrl #(.LD_STALL_CYC(1), .MC_TIMEOUT(TO), .CNT_W(32)) dut_a (
    .clk(clk), .rst(rst), .branch_taken_ex(br), .pc_src_ex(jp),
    .ex_is_load(ld), .ex_rf_wb(wb), .rd_ex(rd), .rs1_dec(rs1),
    .rs2_dec(rs2), .rs1_used(u1), .rs2_used(u2), .ex_mc_op(mc),
    .mc_done(done), .pc_en(pa), .if_id_en(fa_en), .id_ex_en(ia),
    .if_id_flush(ffa), .id_ex_flush(fia), .ex_mem_flush(fea),
    .mc_start(sa), .mc_timeout(ta), .stall_cnt(cnt_a)
  );

  ex_hazard_ctrl #(.LD_STALL_CYC(3), .MC_TIMEOUT(TO), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .branch_taken_ex(br), .pc_src_ex(jp),
    .ex_is_load(ld), .ex_rf_wb(wb), .rd_ex(rd), .rs1_dec(rs1),
    .rs2_dec(rs2), .rs1_used(u1), .rs2_used(u2), .ex_mc_op(mc),
    .mc_done(done), .pc_en(pb), .if_id_en(fb_en), .id_ex_en(ib),
    .if_id_flush(ffb), .id_ex_flush(fib), .ex_mem_flush(feb),
    .mc_start(sb), .mc_timeout(tb), .stall_cnt(cnt_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // model state: index 0 = dut_a, 1 = dut_b
  int     ld_cyc [2] = '{1, 3};
  longint cmax   [2] = '{64'hFFFF_FFFF, 64'd15};
  bit     m_mc   [2];
  int     m_age  [2];
  int     m_ldr  [2];
  bit     m_to   [2];
  longint m_cnt  [2];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic in_t mk(bit r, bit b, bit j, bit l, bit w,
                             logic [4:0] d, logic [4:0] s1,
                             logic [4:0] s2, bit a1, bit a2,
                             bit m, bit dn);
    in_t v;
    v.rst = r; v.br = b; v.jp = j; v.ld = l; v.wb = w;
    v.rd = d; v.rs1 = s1; v.rs2 = s2; v.u1 = a1; v.u2 = a2;
    v.mc = m; v.done = dn;
    return v;
  endfunction

  function automatic logic [6:0] m_out(int k);
    bit lu;
    lu = ld && wb && rd != 0 &&
         ((u1 && rs1 == rd) || (u2 && rs2 == rd));
    if (rst)           return 7'b0001110;
    if (m_mc[k])       return done ? 7'b1110000 : 7'b0000010;
    if (m_ldr[k] > 0)  return 7'b0010100;
    if (br || jp)      return 7'b1111100;
    if (mc)            return 7'b0000011;
    if (lu)            return 7'b0010100;
    return 7'b1110000;
  endfunction

  task automatic m_commit(int k, logic [6:0] o);
    bit lu;
    lu = ld && wb && rd != 0 &&
         ((u1 && rs1 == rd) || (u2 && rs2 == rd));
    if (rst) begin
      m_mc[k] = 0; m_age[k] = 0; m_ldr[k] = 0; m_to[k] = 0; m_cnt[k] = 0;
      return;
    end
    if (!o[6] && m_cnt[k] < cmax[k]) m_cnt[k]++;
    if (m_mc[k]) begin
      if (done) m_mc[k] = 0;
      else begin
        if (m_age[k] == TO - 1) begin
          m_to[k] = 1;
          m_mc[k] = 0;
        end
        m_age[k]++;
      end
    end else if (m_ldr[k] > 0) begin
      m_ldr[k]--;
    end else if (!(br || jp)) begin
      if (mc) begin
        m_mc[k] = 1;
        m_age[k] = 0;
      end else if (lu) begin
        m_ldr[k] = ld_cyc[k] - 1;
      end
    end
  endtask

  task automatic apply(input in_t v);
    rst = v.rst; br = v.br; jp = v.jp; ld = v.ld; wb = v.wb;
    rd = v.rd; rs1 = v.rs1; rs2 = v.rs2; u1 = v.u1; u2 = v.u2;
    mc = v.mc; done = v.done;
  endtask

  // called 1 time unit after a rising edge; returns 1 after the next
  task automatic step(input in_t v, output smp_t s);
    logic [6:0] ea, eb;
    apply(v);
    #2;
    s.oa = {pa, fa_en, ia, ffa, fia, fea, sa};
    s.ob = {pb, fb_en, ib, ffb, fib, feb, sb};
    s.ta = ta; s.tb = tb;
    s.ca = 64'(cnt_a); s.cb = 64'(cnt_b);
    ea = m_out(0);
    eb = m_out(1);
    chk("a_outs", 64'(s.oa), 64'(ea));
    chk("b_outs", 64'(s.ob), 64'(eb));
    chk("a_tmo", 64'(s.ta), 64'(m_to[0]));
    chk("b_tmo", 64'(s.tb), 64'(m_to[1]));
    chk("a_cnt", s.ca, 64'(m_cnt[0]));
    chk("b_cnt", s.cb, 64'(m_cnt[1]));
    @(posedge clk);
    m_commit(0, ea);
    m_commit(1, eb);
    #1;
  endtask

  row_t tbl [15];
  in_t  idle, rsti;
  smp_t s;
  int   stalls, starts, k;

  initial begin
    idle = mk(0,0,0,0,0, 5'd0,5'd0,5'd0, 0,0,0,0);
    rsti = mk(1,0,0,0,0, 5'd0,5'd0,5'd0, 0,0,0,0);
    tbl[0]  = '{rsti, 7'b0001110, 0};
    tbl[1]  = '{idle, 7'b1110000, 0};
    tbl[2]  = '{mk(0,0,0,1,1, 5'd5,5'd5,5'd0, 1,0,0,0), 7'b0010100, 0};
    tbl[3]  = '{idle, 7'b1110000, 1};
    tbl[4]  = '{mk(0,0,0,1,1, 5'd0,5'd0,5'd0, 1,1,0,0), 7'b1110000, 1};
    tbl[5]  = '{mk(0,0,0,1,1, 5'd7,5'd7,5'd7, 0,1,0,0), 7'b0010100, 1};
    tbl[6]  = '{mk(0,0,0,1,1, 5'd7,5'd1,5'd7, 1,0,0,0), 7'b1110000, 2};
    tbl[7]  = '{mk(0,0,0,1,0, 5'd7,5'd7,5'd7, 1,1,0,0), 7'b1110000, 2};
    tbl[8]  = '{mk(0,1,0,1,1, 5'd5,5'd5,5'd0, 1,0,1,0), 7'b1111100, 2};
    tbl[9]  = '{mk(0,0,1,0,0, 5'd0,5'd0,5'd0, 0,0,0,0), 7'b1111100, 2};
    tbl[10] = '{mk(0,0,0,0,0, 5'd0,5'd0,5'd0, 0,0,1,0), 7'b0000011, 2};
    tbl[11] = '{mk(0,0,0,0,0, 5'd0,5'd0,5'd0, 0,0,1,1), 7'b1110000, 3};
    tbl[12] = '{idle, 7'b1110000, 3};
    tbl[13] = '{rsti, 7'b0001110, 3};
    tbl[14] = '{idle, 7'b1110000, 0};

    for (int j = 0; j < 2; j++) begin
      m_mc[j] = 0; m_age[j] = 0; m_ldr[j] = 0; m_to[j] = 0; m_cnt[j] = 0;
    end
    apply(rsti);
    @(posedge clk);
    #1;

    for (int r = 0; r < 15; r++) begin
      step(tbl[r].i, s);
      chk($sformatf("tbl%0d_outs", r), 64'(s.oa), 64'(tbl[r].o));
      chk($sformatf("tbl%0d_cnt", r), s.ca, 64'(tbl[r].cnt));
    end

    // multicycle op completing after three idle wait cycles
    step(rsti, s);
    stalls = 0; starts = 0;
    step(mk(0,0,0,0,0, 5'd0,5'd0,5'd0, 0,0,1,0), s);
    stalls += int'(!s.oa[6]); starts += int'(s.oa[0]);
    for (int j = 0; j < 3; j++) begin
      step(mk(0,0,0,0,0, 5'd0,5'd0,5'd0, 0,0,0,1'b0), s);
      stalls += int'(!s.oa[6]); starts += int'(s.oa[0]);
    end
    step(mk(0,0,0,0,0, 5'd0,5'd0,5'd0, 0,0,0,1), s);
    stalls += int'(!s.oa[6]); starts += int'(s.oa[0]);
    step(idle, s);
    chk("mc_stalls", 64'(stalls), 64'd4);
    chk("mc_starts", 64'(starts), 64'd1);
    chk("mc_cnt", s.ca, 64'd4);

    // multicycle op that never completes
    step(rsti, s);
    stalls = 0;
    step(mk(0,0,0,0,0, 5'd0,5'd0,5'd0, 0,0,1,0), s);
    stalls += int'(!s.oa[6]);
    k = 0;
    while (k < 20) begin
      step(idle, s);
      if (s.oa[6]) break;
      stalls++;
      k++;
    end
    if (k == 20) begin
      n_cmp++; n_bad++;
      $display("FAIL tmo_release: no release within 20 cycles");
    end
    chk("tmo_stalls", 64'(stalls), 64'd9);
    chk("tmo_flag", 64'(s.ta), 64'd1);
    for (int j = 0; j < 3; j++) step(idle, s);
    chk("tmo_sticky", 64'(s.ta), 64'd1);

    // reset in the second wait cycle aborts the op
    step(mk(0,0,0,0,0, 5'd0,5'd0,5'd0, 0,0,1,0), s);
    step(idle, s);
    step(rsti, s);
    chk("abort_rst_outs", 64'(s.oa), 64'b0001110);
    step(idle, s);
    chk("abort_outs", 64'(s.oa), 64'b1110000);
    chk("abort_start", 64'(s.ob[0]), 64'd0);
    chk("abort_tmo", 64'(s.ta), 64'd0);
    chk("abort_cnt", s.ca, 64'd0);
    stalls = 0;
    step(mk(0,0,0,1,1, 5'd9,5'd0,5'd9, 0,1,0,0), s);
    stalls += int'(!s.ob[6]);
    k = 0;
    while (k < 10) begin
      step(idle, s);
      if (s.ob[6]) break;
      stalls++;
      k++;
    end
    if (k == 10) begin
      n_cmp++; n_bad++;
      $display("FAIL ld3_release: no release within 10 cycles");
    end
    chk("ld3_stalls", 64'(stalls), 64'd3);

    // randomized traffic
    for (int n = 0; n < 2000; n++) begin
      in_t v;
      v.rst  = ($urandom_range(99) == 0);
      v.br   = ($urandom_range(7) == 0);
      v.jp   = ($urandom_range(15) == 0);
      v.ld   = ($urandom_range(1) == 0);
      v.wb   = ($urandom_range(3) != 0);
      v.rd   = 5'($urandom_range(3));
      v.rs1  = 5'($urandom_range(3));
      v.rs2  = 5'($urandom_range(3));
      v.u1   = ($urandom_range(1) == 0);
      v.u2   = ($urandom_range(1) == 0);
      v.mc   = ($urandom_range(7) == 0);
      v.done = ($urandom_range(9) == 0);
      step(v, s);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
